// File: rtl/projectile_pkg.sv
// Shared types and the turret angle table for the projectile engine.
package projectile_pkg;

    typedef logic [3:0]        angle_idx_t;
    typedef logic signed [3:0] vel_t;
    typedef logic [9:0]        pos_t;
    // Velocity after SPEED scaling; 5 bits holds +/-14 for SPEED up to 7.
    typedef logic signed [4:0] svel_t;

    localparam angle_idx_t MAX_ANGLE = 4'd8;

    // Unit step per angle index, returned as {dx, dy}; screen Y grows downward.
    function automatic logic [7:0] angle_table(input angle_idx_t idx);
        vel_t dx;
        vel_t dy;
        case (idx)
            4'd0:    begin dx = 4'sd0; dy = -4'sd2; end
            4'd1:    begin dx = 4'sd1; dy = -4'sd2; end
            4'd2:    begin dx = 4'sd2; dy = -4'sd2; end
            4'd3:    begin dx = 4'sd2; dy = -4'sd1; end
            4'd4:    begin dx = 4'sd2; dy = 4'sd0;  end
            4'd5:    begin dx = 4'sd2; dy = 4'sd1;  end
            4'd6:    begin dx = 4'sd2; dy = 4'sd2;  end
            4'd7:    begin dx = 4'sd1; dy = 4'sd2;  end
            default: begin dx = 4'sd0; dy = 4'sd2;  end
        endcase
        return {dx, dy};
    endfunction

endpackage

// File: rtl/projectile_engine_if.sv
// Fire request handshake and per-slot kill lines into the projectile engine.
interface projectile_engine_if
    import projectile_pkg::*;
#(
    parameter int unsigned NUM_SHOTS = 4
);
    logic                 fire_valid;
    logic                 fire_ready;
    angle_idx_t           fire_angle;
    pos_t                 launch_x;
    pos_t                 launch_y;
    logic [NUM_SHOTS-1:0] kill;

    modport master (
        output fire_valid, fire_angle, launch_x, launch_y, kill,
        input  fire_ready
    );

    modport slave (
        input  fire_valid, fire_angle, launch_x, launch_y, kill,
        output fire_ready
    );
endinterface

// File: rtl/projectile_slot.sv
// One projectile slot: position/velocity registers, edge reflection, bounce budget.
module projectile_slot
    import projectile_pkg::*;
#(
    parameter int unsigned SCREEN_W    = 640,
    parameter int unsigned SCREEN_H    = 480,
    parameter int unsigned SPRITE_W    = 40,
    parameter int unsigned SPRITE_H    = 10,
    parameter int unsigned SPEED       = 1,
    parameter int unsigned MAX_BOUNCES = 3
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       step,
    input  logic       load,
    input  angle_idx_t angle,
    input  pos_t       lx,
    input  pos_t       ly,
    input  logic       kill,
    output logic       active,
    output pos_t       x,
    output pos_t       y,
    output logic       vx_neg,
    output logic       vy_neg,
    output logic       bounce_pulse,
    output logic       retire_pulse
);
    localparam logic signed [11:0] X_MAX     = 12'(SCREEN_W - SPRITE_W);
    localparam logic signed [11:0] Y_MAX     = 12'(SCREEN_H - SPRITE_H);
    localparam svel_t              SPEED_S   = svel_t'(SPEED);
    localparam logic [3:0]         BNC_LIMIT = 4'(MAX_BOUNCES);

    logic       active_q, bounce_q, retire_q;
    pos_t       x_q, y_q;
    svel_t      dx_q, dy_q;
    logic [3:0] bnc_q;

    angle_idx_t         angle_c;
    logic [7:0]         entry;
    svel_t              ld_dx, ld_dy;
    logic signed [11:0] nx, ny;
    pos_t               x_d, y_d;
    svel_t              dx_d, dy_d;
    logic               refl_x, refl_y;

    // Launch velocity lookup and candidate next position with edge reflection.
    always_comb begin
        angle_c = (angle > MAX_ANGLE) ? MAX_ANGLE : angle;
        entry   = angle_table(angle_c);
        ld_dx   = $signed({entry[7], entry[7:4]}) * SPEED_S;
        ld_dy   = $signed({entry[3], entry[3:0]}) * SPEED_S;

        nx = $signed({2'b00, x_q}) + $signed({{7{dx_q[4]}}, dx_q});
        ny = $signed({2'b00, y_q}) + $signed({{7{dy_q[4]}}, dy_q});

        x_d    = nx[9:0];
        dx_d   = dx_q;
        refl_x = 1'b0;
        if (nx < 0) begin
            x_d    = '0;
            dx_d   = -dx_q;
            refl_x = 1'b1;
        end else if (nx > X_MAX) begin
            x_d    = X_MAX[9:0];
            dx_d   = -dx_q;
            refl_x = 1'b1;
        end

        y_d    = ny[9:0];
        dy_d   = dy_q;
        refl_y = 1'b0;
        if (ny < 0) begin
            y_d    = '0;
            dy_d   = -dy_q;
            refl_y = 1'b1;
        end else if (ny > Y_MAX) begin
            y_d    = Y_MAX[9:0];
            dy_d   = -dy_q;
            refl_y = 1'b1;
        end
    end

    // Slot state: load beats everything (only free slots load), then kill, then step.
    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            active_q <= 1'b0;
            bounce_q <= 1'b0;
            retire_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            bnc_q    <= '0;
        end else begin
            bounce_q <= 1'b0;
            retire_q <= 1'b0;
            if (load) begin
                active_q <= 1'b1;
                x_q      <= lx;
                y_q      <= ly;
                dx_q     <= ld_dx;
                dy_q     <= ld_dy;
                bnc_q    <= '0;
            end else if (kill && active_q) begin
                active_q <= 1'b0;
                retire_q <= 1'b1;
            end else if (step && active_q) begin
                if ((refl_x || refl_y) && (bnc_q == BNC_LIMIT)) begin
                    // Budget spent: the edge contact retires the shot, position holds.
                    active_q <= 1'b0;
                    retire_q <= 1'b1;
                end else begin
                    x_q  <= x_d;
                    y_q  <= y_d;
                    dx_q <= dx_d;
                    dy_q <= dy_d;
                    if (refl_x || refl_y) begin
                        bnc_q    <= bnc_q + 4'd1;
                        bounce_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign active       = active_q;
    assign x            = x_q;
    assign y            = y_q;
    assign vx_neg       = dx_q[4];
    assign vy_neg       = dy_q[4];
    assign bounce_pulse = bounce_q;
    assign retire_pulse = retire_q;

endmodule

// File: rtl/projectile_engine.sv
// Multi-shot projectile engine: lowest-free-slot allocator and output packing.
module projectile_engine
    import projectile_pkg::*;
#(
    parameter int unsigned NUM_SHOTS   = 4,
    parameter int unsigned SCREEN_W    = 640,
    parameter int unsigned SCREEN_H    = 480,
    parameter int unsigned SPRITE_W    = 40,
    parameter int unsigned SPRITE_H    = 10,
    parameter int unsigned SPEED       = 1,
    parameter int unsigned MAX_BOUNCES = 3
) (
    input  logic                    frame_clk,
    input  logic                    Reset,
    input  logic                    step,
    projectile_engine_if.slave      fire,
    output logic [NUM_SHOTS-1:0]    shot_active,
    output logic [10*NUM_SHOTS-1:0] shot_x,
    output logic [10*NUM_SHOTS-1:0] shot_y,
    output logic [NUM_SHOTS-1:0]    shot_vx_neg,
    output logic [NUM_SHOTS-1:0]    shot_vy_neg,
    output logic [NUM_SHOTS-1:0]    bounce_pulse,
    output logic [NUM_SHOTS-1:0]    retire_pulse
);
    logic                 ready_en_q;
    logic [NUM_SHOTS-1:0] grant;
    logic [NUM_SHOTS-1:0] load;
    logic                 found;

    // Holds fire_ready low through reset and for the first edge afterwards.
    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
        end
    end

    assign fire.fire_ready = ready_en_q & (|(~shot_active));

    // Lowest-index free slot, from the pre-kill mask so a killed slot is not reused this cycle.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_SHOTS; i++) begin
            if (!shot_active[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        load = (fire.fire_valid && fire.fire_ready) ? grant : '0;
    end

    for (genvar i = 0; i < NUM_SHOTS; i++) begin : g_slot
        projectile_slot #(
            .SCREEN_W    (SCREEN_W),
            .SCREEN_H    (SCREEN_H),
            .SPRITE_W    (SPRITE_W),
            .SPRITE_H    (SPRITE_H),
            .SPEED       (SPEED),
            .MAX_BOUNCES (MAX_BOUNCES)
        ) u_slot (
            .frame_clk    (frame_clk),
            .Reset        (Reset),
            .step         (step),
            .load         (load[i]),
            .angle        (fire.fire_angle),
            .lx           (fire.launch_x),
            .ly           (fire.launch_y),
            .kill         (fire.kill[i]),
            .active       (shot_active[i]),
            .x            (shot_x[10*i +: 10]),
            .y            (shot_y[10*i +: 10]),
            .vx_neg       (shot_vx_neg[i]),
            .vy_neg       (shot_vy_neg[i]),
            .bounce_pulse (bounce_pulse[i]),
            .retire_pulse (retire_pulse[i])
        );
    end

endmodule

// File: tb/tb_projectile_engine.sv
// Directed plus randomized bench for projectile_engine against a behavioural model.
module tb_projectile_engine;

    localparam int NS    = 4;
    localparam int XM    = 600;
    localparam int YM    = 470;
    localparam int SPD   = 1;
    localparam int MAXB  = 3;

    logic              frame_clk;
    logic              Reset;
    logic              step;
    logic [NS-1:0]     shot_active;
    logic [10*NS-1:0]  shot_x;
    logic [10*NS-1:0]  shot_y;
    logic [NS-1:0]     shot_vx_neg;
    logic [NS-1:0]     shot_vy_neg;
    logic [NS-1:0]     bounce_pulse;
    logic [NS-1:0]     retire_pulse;

    projectile_engine_if #(.NUM_SHOTS(NS)) fire_bus ();

    projectile_engine #(
        .NUM_SHOTS   (NS),
        .SCREEN_W    (640),
        .SCREEN_H    (480),
        .SPRITE_W    (40),
        .SPRITE_H    (10),
        .SPEED       (SPD),
        .MAX_BOUNCES (MAXB)
    ) dut (
        .frame_clk    (frame_clk),
        .Reset        (Reset),
        .step         (step),
        .fire         (fire_bus.slave),
        .shot_active  (shot_active),
        .shot_x       (shot_x),
        .shot_y       (shot_y),
        .shot_vx_neg  (shot_vx_neg),
        .shot_vy_neg  (shot_vy_neg),
        .bounce_pulse (bounce_pulse),
        .retire_pulse (retire_pulse)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: plain integers per slot.
    int          tdx[9] = '{0, 1, 2, 2, 2, 2, 2, 1, 0};
    int          tdy[9] = '{-2, -2, -2, -1, 0, 1, 2, 2, 2};
    int          m_x[NS], m_y[NS], m_dx[NS], m_dy[NS], m_b[NS];
    logic [NS-1:0] m_act, e_bp, e_rp;
    bit          m_rdy_en;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_x[i] = 0; m_y[i] = 0; m_dx[i] = 0; m_dy[i] = 0; m_b[i] = 0;
        end
        m_act = '0; e_bp = '0; e_rp = '0; m_rdy_en = 0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".active"}, shot_active, m_act);
        chk({tag, ".bounce"}, bounce_pulse, e_bp);
        chk({tag, ".retire"}, retire_pulse, e_rp);
        chk({tag, ".ready"}, fire_bus.fire_ready, m_rdy_en && (m_act != '1));
        for (int i = 0; i < NS; i++) begin
            chk($sformatf("%s.x%0d", tag, i), shot_x[10*i +: 10], m_x[i]);
            chk($sformatf("%s.y%0d", tag, i), shot_y[10*i +: 10], m_y[i]);
            chk($sformatf("%s.vxn%0d", tag, i), shot_vx_neg[i], m_dx[i] < 0);
            chk($sformatf("%s.vyn%0d", tag, i), shot_vy_neg[i], m_dy[i] < 0);
        end
    endtask

    // One frame_clk cycle: drive inputs, advance the model, compare after the edge.
    task automatic tick(input string tag, input logic fv, input int ang, input int lx,
                        input int ly, input logic [NS-1:0] kl, input logic st);
        int  sel, a, nx, ny, vx, vy;
        bit  rdy, hit;
        @(negedge frame_clk);
        fire_bus.fire_valid = fv;
        fire_bus.fire_angle = 4'(ang);
        fire_bus.launch_x   = 10'(lx);
        fire_bus.launch_y   = 10'(ly);
        fire_bus.kill       = kl;
        step                = st;
        #1;
        rdy = m_rdy_en && (m_act != '1);
        chk({tag, ".ready_pre"}, fire_bus.fire_ready, rdy);
        sel = -1;
        if (fv && rdy) begin
            for (int i = 0; i < NS; i++) if (!m_act[i] && sel < 0) sel = i;
        end
        for (int i = 0; i < NS; i++) begin
            e_bp[i] = 1'b0;
            e_rp[i] = 1'b0;
            if (i == sel) begin
                a = (ang > 8) ? 8 : ang;
                m_act[i] = 1'b1; m_x[i] = lx; m_y[i] = ly;
                m_dx[i] = tdx[a] * SPD; m_dy[i] = tdy[a] * SPD; m_b[i] = 0;
            end else if (kl[i] && m_act[i]) begin
                m_act[i] = 1'b0; e_rp[i] = 1'b1;
            end else if (st && m_act[i]) begin
                nx = m_x[i] + m_dx[i]; ny = m_y[i] + m_dy[i];
                vx = m_dx[i]; vy = m_dy[i]; hit = 0;
                if (nx < 0) begin nx = 0; vx = -vx; hit = 1; end
                else if (nx > XM) begin nx = XM; vx = -vx; hit = 1; end
                if (ny < 0) begin ny = 0; vy = -vy; hit = 1; end
                else if (ny > YM) begin ny = YM; vy = -vy; hit = 1; end
                if (hit && m_b[i] == MAXB) begin
                    m_act[i] = 1'b0; e_rp[i] = 1'b1;
                end else begin
                    m_x[i] = nx; m_y[i] = ny; m_dx[i] = vx; m_dy[i] = vy;
                    if (hit) begin m_b[i]++; e_bp[i] = 1'b1; end
                end
            end
        end
        @(posedge frame_clk);
        #1;
        check_state(tag);
    endtask

    task automatic step_n(input string tag, input int n);
        for (int k = 0; k < n; k++) tick(tag, 1'b0, 0, 0, 0, '0, 1'b1);
    endtask

    task automatic clear_all();
        tick("clear", 1'b0, 0, 0, 0, '1, 1'b0);
        tick("idle", 1'b0, 0, 0, 0, '0, 1'b0);
    endtask

    initial begin
        int nb;
        bit retired;
        Reset = 1'b0;
        step  = 1'b0;
        fire_bus.fire_valid = 1'b0;
        fire_bus.fire_angle = '0;
        fire_bus.launch_x   = '0;
        fire_bus.launch_y   = '0;
        fire_bus.kill       = '0;
        model_reset();

        // 1: reset state, then ready one edge after release
        repeat (3) @(posedge frame_clk);
        #1;
        chk("rst.active", shot_active, 0);
        chk("rst.x", shot_x, 0);
        chk("rst.y", shot_y, 0);
        chk("rst.pulses", {bounce_pulse, retire_pulse, shot_vx_neg, shot_vy_neg}, 0);
        chk("rst.ready", fire_bus.fire_ready, 0);
        @(negedge frame_clk);
        Reset = 1'b1;
        @(posedge frame_clk);
        #1;
        chk("rst.ready_after", fire_bus.fire_ready, 1);
        m_rdy_en = 1;

        // 2: horizontal shot to the right edge
        tick("t2.fire", 1'b1, 4, 90, 52, '0, 1'b0);
        step_n("t2.run", 255);
        chk("t2.x255", shot_x[9:0], 600);
        chk("t2.y255", shot_y[9:0], 52);
        step_n("t2.s256", 1);
        chk("t2.x256", shot_x[9:0], 600);
        chk("t2.vxn256", shot_vx_neg[0], 1);
        chk("t2.bp256", bounce_pulse[0], 1);
        step_n("t2.s257", 1);
        chk("t2.x257", shot_x[9:0], 598);
        chk("t2.bp257", bounce_pulse[0], 0);
        clear_all();

        // 3: corner reflection counts once
        tick("t3.fire", 1'b1, 6, 596, 466, '0, 1'b0);
        step_n("t3.s", 2);
        chk("t3.xy2", {shot_x[9:0], shot_y[9:0]}, {10'd600, 10'd470});
        step_n("t3.s3", 1);
        chk("t3.xy3", {shot_x[9:0], shot_y[9:0]}, {10'd600, 10'd470});
        chk("t3.neg", {shot_vx_neg[0], shot_vy_neg[0]}, 2'b11);
        chk("t3.bp", bounce_pulse, 4'b0001);
        clear_all();

        // 4: fill all slots, kill+fire in same cycle, then refill slot 2
        for (int i = 0; i < NS; i++) tick("t4.fill", 1'b1, i, 10 * i, 20 * i, '0, 1'b0);
        chk("t4.full", shot_active, 4'hF);
        chk("t4.notready", fire_bus.fire_ready, 0);
        tick("t4.fifth", 1'b1, 5, 300, 300, '0, 1'b0);
        tick("t4.killfire", 1'b1, 5, 300, 300, 4'b0100, 1'b0);
        chk("t4.killed", shot_active, 4'b1011);
        tick("t4.refire", 1'b1, 7, 321, 123, '0, 1'b0);
        chk("t4.slot2", {shot_active[2], shot_x[29:20], shot_y[29:20]}, {1'b1, 10'd321, 10'd123});
        clear_all();

        // 5: bounce budget then retire on the next edge contact
        tick("t5.fire", 1'b1, 0, 100, 20, '0, 1'b0);
        nb = 0;
        retired = 0;
        for (int k = 0; k < 1200 && !retired; k++) begin
            step_n("t5.run", 1);
            if (bounce_pulse[0]) nb++;
            if (retire_pulse[0]) retired = 1;
        end
        chk("t5.bounces", nb, 3);
        chk("t5.retired", retired, 1);
        chk("t5.inactive", shot_active[0], 0);

        // 6: reset during flight clears asynchronously without retire pulses
        tick("t6.f0", 1'b1, 2, 200, 200, '0, 1'b0);
        tick("t6.f1", 1'b1, 7, 300, 100, '0, 1'b0);
        step_n("t6.run", 5);
        #2;
        Reset = 1'b0;
        #1;
        chk("t6.active", shot_active, 0);
        chk("t6.retire", retire_pulse, 0);
        chk("t6.ready", fire_bus.fire_ready, 0);
        model_reset();
        @(negedge frame_clk);
        Reset = 1'b1;
        @(posedge frame_clk);
        #1;
        m_rdy_en = 1;
        chk("t6.ready_after", fire_bus.fire_ready, 1);

        // Randomized traffic, including out-of-range angles and kills on free slots
        for (int k = 0; k < 2000; k++) begin
            tick("rnd",
                 $urandom_range(0, 99) < 25,
                 $urandom_range(0, 15),
                 $urandom_range(0, XM),
                 $urandom_range(0, YM),
                 ($urandom_range(0, 99) < 8) ? NS'($urandom) : '0,
                 $urandom_range(0, 99) < 80);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/projectile_engine.md
Name: projectile_engine

Overview:
Multi-shot projectile motion engine for the turret game. It replaces the single hard-wired horizontal bullet with NUM_SHOTS independent projectile slots. Each shot launches at one of nine turret angles, reflects off all four screen edges, and retires after a bounce budget or on an external kill. Outputs feed the sprite-draw and hit-detect logic directly.

Parameters:
NUM_SHOTS, 4, number of projectile slots
SCREEN_W, 640, playfield width in pixels
SCREEN_H, 480, playfield height in pixels
SPRITE_W, 40, projectile bounding-box width
SPRITE_H, 10, projectile bounding-box height
SPEED, 1, velocity multiplier applied to the angle table (1..7)
MAX_BOUNCES, 3, edge reflections allowed before retire (0..15)

Ports:
frame_clk  input  1  clock; one motion update per step
Reset  input  1  asynchronous, active-low reset
step  input  1  advance all active shots by one motion tick
fire_valid  input  1  launch request
fire_ready  output  1  high when any slot is free
fire_angle  input  4  turret angle index 0..8 (0=90°, 1=60°, 2=45°, 3=30°, 4=0°, 5=330°, 6=315°, 7=300°, 8=270°)
launch_x  input  10  launch top-left X
launch_y  input  10  launch top-left Y
kill  input  NUM_SHOTS  per-slot retire request from hit detection
shot_active  output  NUM_SHOTS  slot occupied
shot_x  output  10*NUM_SHOTS  top-left X per slot; slot i occupies bits [10i+9:10i]
shot_y  output  10*NUM_SHOTS  top-left Y per slot, same packing
shot_vx_neg  output  NUM_SHOTS  current X velocity is negative (sprite orientation select)
shot_vy_neg  output  NUM_SHOTS  current Y velocity is negative
bounce_pulse  output  NUM_SHOTS  one-cycle pulse on a reflection
retire_pulse  output  NUM_SHOTS  one-cycle pulse when a slot frees

Behaviour:
- Reset (async, Reset=0): all outputs 0; all slots free; all position, velocity and bounce counters 0. fire_ready rises the first cycle after Reset deasserts. Reset mid-flight clears every shot immediately.
- fire_ready is combinational: the OR of ~shot_active over the registered state. A launch is accepted when fire_valid && fire_ready. The accepted request goes to the lowest-index free slot.
- Launch load, taking effect at the next edge:
  - position = (launch_x, launch_y); bounce count = 0; shot_active = 1.
  - velocity = ANGLE_TABLE[fire_angle] * SPEED.
  - fire_angle > 8 is clamped to 8.
  - A slot launched in a step cycle does not move that cycle.
- ANGLE_TABLE (dx, dy), screen Y grows downward:
  - 0:(0,-2), 1:(1,-2), 2:(2,-2), 3:(2,-1), 4:(2,0)
  - 5:(2,1), 6:(2,2), 7:(1,2), 8:(0,2)
- Kill:
  - kill[i] on an active slot frees it at the next edge and pulses retire_pulse[i].
  - kill takes priority over step and over bounce.
  - kill on a free slot is ignored.
  - A slot freed by kill is not available to a fire in the same cycle, because allocation uses the pre-kill mask.
- Step, for each active, un-killed slot:
  - Compute nx = x + dx and ny = y + dy, signed 12-bit.
  - X limits: if nx < 0, set x = 0 and negate dx. If nx > SCREEN_W-SPRITE_W, set x = SCREEN_W-SPRITE_W and negate dx. Otherwise x = nx.
  - Y uses the same rule against 0 and SCREEN_H-SPRITE_H.
  - Any reflection in the tick (X, Y, or both at a corner) counts as exactly one bounce and pulses bounce_pulse[i].
  - If the bounce count already equals MAX_BOUNCES, the slot retires instead: active=0, retire_pulse[i]=1, no bounce_pulse.
- No step: positions and velocities hold.
- Pulses last exactly one cycle.
- shot_x and shot_y hold their last value after retire.
- shot_vx_neg and shot_vy_neg are the sign bits of the stored velocities.

Decomposition:
- Package projectile_pkg holds:
  - angle_idx_t (4-bit);
  - vel_t (signed 4-bit);
  - the ANGLE_TABLE constant function returning {dx, dy};
  - a pos_t (10-bit) typedef.
- Sub-module projectile_slot holds one slot's registers, edge-reflect arithmetic and bounce counter. It is instantiated NUM_SHOTS times by a generate loop.
- The top level holds the priority-encoder allocator and the output packing.

Test Plan:
1. Reset with all inputs 0 -> every output 0; fire_ready=1 one cycle after Reset goes to 1.
2. Defaults. Fire angle 4 at (90,52), then step x255 -> shot_x[0]=600, y=52.
   - Step 256 -> x=600, vx_neg=1, bounce_pulse[0] for one cycle.
   - Step 257 -> x=598.
3. Corner. Fire angle 6 at (596,466), then step x3 -> (598,468), (600,470), then (600,470) with vx_neg=vy_neg=1 and a single bounce_pulse.
4. Fill all 4 slots -> fire_ready=0; a fifth fire is not accepted.
   - kill[2] plus fire_valid in the same cycle -> no launch that cycle.
   - Next cycle fire_ready=1 and the fire lands in slot 2.
5. MAX_BOUNCES=3, angle 0 at (100,20), step repeatedly -> three bounce_pulses; at the 4th edge contact, retire_pulse[0] and shot_active[0]=0 with no bounce_pulse.
6. Reset asserted while 2 shots are in flight -> shot_active=0 immediately (asynchronously); no retire_pulse emitted.
